// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings and the default datapath width shared by the ALU and its arbiter.
package alu_pkg;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
    localparam int         ALU_W    = 16;
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/nand unit with zero detect; any op other than add/sub falls through to nand.
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         zero
);
    always_comb begin
        y    = (op == ALU_ADD) ? a + b : (op == ALU_SUB) ? a - b : ~(a & b);
        zero = (y == '0);
    end
endmodule

// File: rtl/alu_arbiter_rr_grant.sv
// rr_grant: rotating-priority picker; the first valid bit at or after ptr (wrapping modulo N) wins.
module rr_grant #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Walk offsets from farthest to nearest so the nearest valid bit is the last written.
        for (int k = N - 1; k >= 0; k--) begin
            if (enable && valid[(int'(ptr) + k) % N]) begin
                onehot                        = '0;
                onehot[(int'(ptr) + k) % N]   = 1'b1;
                idx                           = IW'((int'(ptr) + k) % N);
                any                           = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU with a registered, backpressured response and the Z flag.
// ALU_FETCH_PRIO_EN: when defined, requester 0 (fetch) always wins and round-robin covers 1..N_REQ-1.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int W     = ALU_W,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_op,
    input  logic [W*N_REQ-1:0]   req_a,
    input  logic [W*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_setz,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_z,
    output logic                 z_flag
);
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_z_q, rsp_z_d;
    logic             z_flag_q, z_flag_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             can_issue, fetch, xfer, adv;
    logic [N_REQ-1:0] rr_valid, rr_onehot;
    logic [IDW-1:0]   rr_idx, gnt_idx;
    logic             rr_any;
    logic [W-1:0]     alu_y;
    logic             alu_zero;

    // Holding off grants while in reset keeps req_ready low even though rsp_valid is clear.
    assign can_issue = (!rsp_valid_q || rsp_ready) && rst_n;

`ifdef ALU_FETCH_PRIO_EN
    assign fetch    = req_valid[0] && can_issue;
    assign rr_valid = req_valid & ~N_REQ'(1);
`else
    assign fetch    = 1'b0;
    assign rr_valid = req_valid;
`endif

    rr_grant #(.N(N_REQ), .IW(IDW)) u_grant (
        .valid  (rr_valid),
        .ptr    (rr_ptr_q),
        .enable (can_issue && !fetch),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .any    (rr_any)
    );

    assign req_ready = fetch ? N_REQ'(1) : rr_onehot;
    assign gnt_idx   = fetch ? '0 : rr_idx;
    assign xfer      = fetch || rr_any;
    assign adv       = rr_any;

    alu #(.W(W)) u_alu (
        .op   (req_op[2*gnt_idx +: 2]),
        .a    (req_a[W*gnt_idx +: W]),
        .b    (req_b[W*gnt_idx +: W]),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_comb begin
        rsp_valid_d = xfer ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_id_d    = xfer ? gnt_idx : rsp_id_q;
        rsp_data_d  = xfer ? alu_y : rsp_data_q;
        rsp_z_d     = xfer ? alu_zero : rsp_z_q;
        z_flag_d    = (xfer && req_setz[gnt_idx]) ? alu_zero : z_flag_q;
        rr_ptr_d    = !adv ? rr_ptr_q : (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_z_q     <= 1'b0;
            z_flag_q    <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_z_q     <= rsp_z_d;
            z_flag_q    <= z_flag_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_z     = rsp_z_q;
    assign z_flag    = z_flag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed steps against a grant/ALU model with a response scoreboard queue.
module tb_alu_arbiter;
    localparam int N = 3;
    localparam int W = 16;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
        logic         z;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   req_setz = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_z;
    logic           z_flag;

    int   total = 0;
    int   fails = 0;
    rsp_t sb[$];
    logic m_rv = 1'b0;
    logic m_z = 1'b0;
    int   m_ptr = 0;

    alu_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_setz  (req_setz),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_z     (rsp_z),
        .z_flag    (z_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic setz);
        req_op[2*i +: 2] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
        req_setz[i]      = setz;
    endtask

    function automatic logic [W-1:0] model_alu(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            default: return ~(a & b);
        endcase
    endfunction

    // One clock: check the grant, score the consumed response, advance the model, then check outputs.
    task automatic step(input string tag);
        logic   can;
        int     gi;
        logic [N-1:0] g;
        rsp_t   r;
        #1;
        can = !m_rv || rsp_ready;
        gi  = -1;
`ifdef ALU_FETCH_PRIO_EN
        if (can && req_valid[0]) gi = 0;
`endif
        for (int k = 0; k < N && gi < 0 && can; k++) begin
            int j;
            j = (m_ptr + k) % N;
`ifdef ALU_FETCH_PRIO_EN
            if (j != 0 && req_valid[j]) gi = j;
`else
            if (req_valid[j]) gi = j;
`endif
        end
        g = (gi >= 0) ? N'(1 << gi) : '0;
        chk({tag, ".ready"}, 32'(req_ready), 32'(g));
        if (m_rv && rsp_ready && sb.size() > 0) void'(sb.pop_front());
        if (gi >= 0) begin
            r.id   = 2'(gi);
            r.data = model_alu(req_op[2*gi +: 2], req_a[W*gi +: W], req_b[W*gi +: W]);
            r.z    = (r.data == '0);
            sb.push_back(r);
            if (req_setz[gi]) m_z = r.z;
`ifdef ALU_FETCH_PRIO_EN
            if (gi != 0) m_ptr = (gi + 1) % N;
`else
            m_ptr = (gi + 1) % N;
`endif
            m_rv = 1'b1;
        end else if (rsp_ready) begin
            m_rv = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_rv));
        chk({tag, ".z_flag"}, 32'(z_flag), 32'(m_z));
        if (m_rv) begin
            r = sb[0];
            chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(r.id));
            chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(r.data));
            chk({tag, ".rsp_z"}, 32'(rsp_z), 32'(r.z));
        end
    endtask

    initial begin
        req_valid = 3'b111;
        #3;
        chk("reset.ready", 32'(req_ready), 32'h0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset.data", 32'(rsp_data), 32'h0);
        chk("reset.z_flag", 32'(z_flag), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request with known sum, then literal-value checks.
        set_req(0, 2'b00, 16'h0005, 16'h0003, 1'b1);
        req_valid = 3'b001;
        step("single");
        chk("single.lit_data", 32'(rsp_data), 32'h0008);
        chk("single.lit_z", 32'(z_flag), 32'h0);
        req_valid = '0;
        step("idle0");

        set_req(1, 2'b01, 16'h1234, 16'h1234, 1'b1);
        req_valid = 3'b010;
        step("zero_sub");
        chk("zero_sub.lit_z", 32'(z_flag), 32'h1);
        set_req(2, 2'b00, 16'h0001, 16'h0001, 1'b0);
        req_valid = 3'b100;
        step("add_noz");
        chk("add_noz.lit_z", 32'(z_flag), 32'h1);
        req_valid = '0;
        step("idle1");

        set_req(0, 2'b00, 16'h0100, 16'h0023, 1'b0);
        set_req(1, 2'b01, 16'h0050, 16'h0060, 1'b1);
        set_req(2, 2'b10, 16'hAAAA, 16'hFFFF, 1'b0);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) step($sformatf("rr%0d", i));

        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("bp%0d", i));
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) step($sformatf("resume%0d", i));
        req_valid = '0;
        step("idle2");

        req_valid = 3'b001;
        set_req(0, 2'b00, 16'hFFFF, 16'h0001, 1'b0);
        step("wrap");
        chk("wrap.lit_data", 32'(rsp_data), 32'h0000);
        set_req(0, 2'b11, 16'hFFFF, 16'hFFFF, 1'b0);
        step("nand11");
        chk("nand11.lit_data", 32'(rsp_data), 32'h0000);
        set_req(0, 2'b10, 16'h0F0F, 16'h00FF, 1'b0);
        step("nand10");
        chk("nand10.lit_data", 32'(rsp_data), 32'hFFF0);
        req_valid = '0;
        step("idle3");

        // Leave a response pending with the pointer at 2, then reset asynchronously.
        set_req(1, 2'b00, 16'h0007, 16'h0001, 1'b1);
        req_valid = 3'b010;
        rsp_ready = 1'b0;
        step("pre_rst");
        req_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst.rsp_id", 32'(rsp_id), 32'h0);
        chk("arst.data", 32'(rsp_data), 32'h0);
        chk("arst.ready", 32'(req_ready), 32'h0);
        sb.delete();
        m_rv = 1'b0;
        m_z = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step("post_rst");
        step("post_rst2");
        req_valid = '0;
        step("idle4");
        chk("drained", 32'(sb.size()), 32'(m_rv ? 1 : 0));

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
